// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: debounced five-button entry of a signed two-digit BCD operand with valid/ready commit.
// Optional AUTO_REPEAT_EN macro adds auto-repeat on held up/down buttons.
module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_sign,
  input  logic       btn_enter,
  output logic [3:0] user_msd,
  output logic [3:0] user_lsd,
  output logic       input_sign,
  output logic       active_digit,
  output logic       entry_valid,
  input  logic       entry_ready,
  output logic [3:0] operand_msd,
  output logic [3:0] operand_lsd,
  output logic       operand_sign
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {S_EDIT, S_WAIT} state_t;
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
  end
  logic [4:0] raw, prs, ev;
  assign raw = {btn_enter, btn_sign, btn_sel, btn_down, btn_up};
  for (genvar b = 0; b < 5; b++) begin : g_db
    logic s1_q, s2_q, lvl_q, lvl_d, prv_q;
    logic [DW-1:0] cnt_q, cnt_d;
    always_comb begin
      lvl_d = (s2_q != lvl_q && cnt_q == DW'(DEBOUNCE_CYCLES - 1)) ? s2_q : lvl_q;
      cnt_d = (s2_q == lvl_q || cnt_q == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        prv_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= raw[b];
        s2_q  <= s1_q;
        lvl_q <= lvl_d;
        prv_q <= lvl_q;
        cnt_q <= cnt_d;
      end
    end
    assign prs[b] = lvl_q & ~prv_q;
  end
`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [1:0] lvl;
  logic [RW-1:0] ru_q, ru_d, rd_q, rd_d;
  logic fire_u, fire_d;
  assign lvl = {g_db[1].lvl_q, g_db[0].lvl_q};
  // Counters reload to DELAY-PERIOD+1 after each fire so later repeats come every PERIOD cycles.
  always_comb begin
    fire_u = lvl[0] && ru_q == RW'(REPEAT_DELAY);
    fire_d = lvl[1] && rd_q == RW'(REPEAT_DELAY);
    ru_d   = !lvl[0] ? '0 : fire_u ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : ru_q + 1'b1;
    rd_d   = !lvl[1] ? '0 : fire_d ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rd_q + 1'b1;
    ev     = prs | {3'b000, fire_d & ~lvl[0], fire_u};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ru_q <= '0;
      rd_q <= '0;
    end else begin
      ru_q <= ru_d;
      rd_q <= rd_d;
    end
  end
`else
  assign ev = prs;
`endif
  state_t state_q, state_d;
  logic [3:0] msd_q, msd_d, lsd_q, lsd_d, om_q, om_d, ol_q, ol_d, cur, nxt;
  logic sign_q, sign_d, act_q, act_d, valid_q, valid_d, os_q, os_d;
  always_comb begin
    state_d = state_q;
    msd_d   = msd_q;
    lsd_d   = lsd_q;
    sign_d  = sign_q;
    act_d   = act_q;
    valid_d = valid_q;
    om_d    = om_q;
    ol_d    = ol_q;
    os_d    = os_q;
    cur     = act_q ? msd_q : lsd_q;
    nxt     = ev[0] ? ((cur == 4'd9) ? 4'd0 : cur + 4'd1) : ((cur == 4'd0) ? 4'd9 : cur - 4'd1);
    if (state_q == S_EDIT) begin
      if (ev[4]) begin
        om_d    = msd_q;
        ol_d    = lsd_q;
        os_d    = sign_q & |{msd_q, lsd_q};
        valid_d = 1'b1;
        state_d = S_WAIT;
      end else if (ev[3]) sign_d = ~sign_q;
      else if (ev[2]) act_d = ~act_q;
      else if (ev[0] || ev[1]) begin
        msd_d = act_q ? nxt : msd_q;
        lsd_d = act_q ? lsd_q : nxt;
      end
    end else if (valid_q && entry_ready) begin
      valid_d = 1'b0;
      msd_d   = 4'd0;
      lsd_d   = 4'd0;
      sign_d  = 1'b0;
      act_d   = 1'b0;
      state_d = S_EDIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EDIT;
      msd_q   <= '0;
      lsd_q   <= '0;
      sign_q  <= 1'b0;
      act_q   <= 1'b0;
      valid_q <= 1'b0;
      om_q    <= '0;
      ol_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      msd_q   <= msd_d;
      lsd_q   <= lsd_d;
      sign_q  <= sign_d;
      act_q   <= act_d;
      valid_q <= valid_d;
      om_q    <= om_d;
      ol_q    <= ol_d;
      os_q    <= os_d;
    end
  end
  assign user_msd     = msd_q;
  assign user_lsd     = lsd_q;
  assign input_sign   = sign_q;
  assign active_digit = act_q;
  assign entry_valid  = valid_q;
  assign operand_msd  = om_q;
  assign operand_lsd  = ol_q;
  assign operand_sign = os_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry: directed and random button sequences checked against a value-level entry model.
// Define AUTO_REPEAT_EN to check the auto-repeat build.
module tb_bcd_operand_entry;
  localparam int RD = 20;
  localparam int RP = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic entry_ready = 1'b0;
  logic [3:0] user_msd, user_lsd, operand_msd, operand_lsd;
  logic input_sign, active_digit, entry_valid, operand_sign;
  int checks = 0;
  int errors = 0;
  int m_msd, m_lsd, m_om, m_ol;
  bit m_sign, m_act, m_wait, m_os;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_sel(btn[2]), .btn_sign(btn[3]), .btn_enter(btn[4]),
    .user_msd(user_msd), .user_lsd(user_lsd), .input_sign(input_sign), .active_digit(active_digit),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .operand_msd(operand_msd), .operand_lsd(operand_lsd), .operand_sign(operand_sign)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_msd = 0; m_lsd = 0; m_om = 0; m_ol = 0;
    m_sign = 0; m_act = 0; m_wait = 0; m_os = 0;
  endfunction

  // Only the highest-priority button in a simultaneous press acts: enter, sign, sel, up, down.
  function automatic void model_press(input logic [4:0] m);
    int d;
    if (m_wait) return;
    if (m[4]) begin
      m_om = m_msd; m_ol = m_lsd;
      m_os = m_sign && (m_msd * 10 + m_lsd) != 0;
      m_wait = 1;
    end else if (m[3]) m_sign = !m_sign;
    else if (m[2]) m_act = !m_act;
    else if (m[0] || m[1]) begin
      d = m_act ? m_msd : m_lsd;
      d = (d + (m[0] ? 1 : 9)) % 10;
      if (m_act) m_msd = d; else m_lsd = d;
    end
  endfunction

  function automatic int up_events(input int held);
    int n = 1;
`ifdef AUTO_REPEAT_EN
    for (int k = RD; k < held; k += RP) n++;
`endif
    return n;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input int exp);
    checks++;
    assert (got === 8'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".msd"}, {4'd0, user_msd}, m_msd);
    chk({t, ".lsd"}, {4'd0, user_lsd}, m_lsd);
    chk({t, ".sign"}, {7'd0, input_sign}, int'(m_sign));
    chk({t, ".act"}, {7'd0, active_digit}, int'(m_act));
    chk({t, ".valid"}, {7'd0, entry_valid}, int'(m_wait));
    chk({t, ".op_msd"}, {4'd0, operand_msd}, m_om);
    chk({t, ".op_lsd"}, {4'd0, operand_lsd}, m_ol);
    chk({t, ".op_sign"}, {7'd0, operand_sign}, int'(m_os));
  endtask

  task automatic press(input logic [4:0] m, input int h);
    btn = m;
    repeat (h) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
  endtask

  task automatic handshake(input int dly);
    repeat (dly) @(negedge clk);
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    if (m_wait) begin
      m_wait = 0; m_msd = 0; m_lsd = 0; m_sign = 0; m_act = 0;
    end
    check_all("handshake");
  endtask

  initial begin
    logic [4:0] m;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");
    // first press: update must appear exactly 7 edges after the raw edge
    btn = 5'b00001;
    repeat (6) @(negedge clk);
    chk("lat_early", {4'd0, user_lsd}, 0);
    @(negedge clk);
    chk("lat_on", {4'd0, user_lsd}, 1);
    model_press(5'b00001);
    @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    repeat (2) begin press(5'b00001, 6); model_press(5'b00001); end
    check_all("three_up");
    repeat (2) begin
      btn = 5'b00001; repeat (3) @(negedge clk);
      btn = '0; repeat (3) @(negedge clk);
    end
    press(5'b00001, 10); model_press(5'b00001);
    check_all("glitch");
    repeat (4) begin press(5'b00010, 5); model_press(5'b00010); end
    check_all("down_to_0");
    press(5'b00010, 5); model_press(5'b00010);
    check_all("down_wrap");
    press(5'b00001, 5); model_press(5'b00001);
    check_all("up_wrap");
    press(5'b00100, 5); model_press(5'b00100);
    repeat (4) begin press(5'b00001, 5); model_press(5'b00001); end
    press(5'b01000, 5); model_press(5'b01000);
    check_all("msd4_neg");
    press(5'b10000, 5); model_press(5'b10000);
    check_all("enter_m40");
    repeat (20) @(negedge clk);
    press(5'b00001, 6); model_press(5'b00001);
    check_all("wait_hold");
    handshake(0);
    press(5'b01000, 5); model_press(5'b01000);
    press(5'b10000, 5); model_press(5'b10000);
    check_all("neg_zero");
    handshake(2);
    press(5'b11000, 6); model_press(5'b11000);
    check_all("sign_enter");
    handshake(1);
    press(5'b00001, 50);
    repeat (up_events(50)) model_press(5'b00001);
    check_all("hold_up");
    for (int i = 0; i < 40; i++) begin
      m = 5'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) m |= 5'(1 << $urandom_range(0, 4));
      press(m, $urandom_range(5, 10));
      model_press(m);
      check_all("rand");
      if (m_wait) handshake($urandom_range(0, 5));
    end
    press(5'b00100, 5); model_press(5'b00100);
    press(5'b00001, 5); model_press(5'b00001);
    press(5'b10000, 5); model_press(5'b10000);
    check_all("pre_rst");
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
